// File: rtl/dma_bus_sequencer.sv
// Single-channel DMA sequencer: requests the shared bus, then copies words one at a
// time (read source, write destination) with target decode and a fairness limit.
module dma_bus_sequencer #(
    parameter int unsigned IO1_BASE   = 192,
    parameter int unsigned IO2_BASE   = 224,
    parameter int unsigned FAIR_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [7:0]  desc_src,
    input  logic [7:0]  desc_dest,
    input  logic [5:0]  desc_count,
    output logic        bus_req,
    input  logic        grant,
    output logic        busybus,
    output logic [7:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_oe,
    output logic        memwrite,
    output logic        IOWrite1,
    output logic        IOWrite2,
    output logic        done,
    output logic [5:0]  remaining
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_READ, S_WRITE, S_YIELD, S_DONE
    } state_t;

    localparam logic [7:0] IO1_B  = 8'(IO1_BASE);
    localparam logic [7:0] IO2_B  = 8'(IO2_BASE);
    // A grant can move at most 63 words, so 7 bits covers any useful limit.
    localparam logic [6:0] FAIR_L = 7'(FAIR_LIMIT);

    state_t      state_q, state_d;
    logic [7:0]  src_q, src_d;
    logic [7:0]  dest_q, dest_d;
    logic [5:0]  rem_q, rem_d;
    logic [31:0] hold_q, hold_d;
    logic [6:0]  burst_q, burst_d;
    logic [7:0]  addr_q, addr_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dest_q  <= '0;
            rem_q   <= '0;
            hold_q  <= '0;
            burst_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dest_q  <= dest_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dest_d     = dest_q;
        rem_d      = rem_q;
        hold_d     = hold_q;
        burst_d    = burst_q;
        addr_d     = addr_q;
        desc_ready = 1'b0;
        bus_req    = 1'b0;
        busybus    = 1'b0;
        address    = addr_q;
        data_oe    = 1'b0;
        memwrite   = 1'b0;
        IOWrite1   = 1'b0;
        IOWrite2   = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                desc_ready = 1'b1;
                if (desc_valid) begin
                    src_d   = desc_src;
                    dest_d  = desc_dest;
                    rem_d   = desc_count;
                    burst_d = '0;
                    state_d = (desc_count == 6'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (grant) state_d = S_READ;
            end
            S_READ: begin
                bus_req = 1'b1;
                busybus = 1'b1;
                address = src_q;
                addr_d  = src_q;
                hold_d  = data_in;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                bus_req = 1'b1;
                busybus = 1'b1;
                address = dest_q;
                addr_d  = dest_q;
                data_oe = 1'b1;
                if (dest_q < IO1_B)      memwrite = 1'b1;
                else if (dest_q < IO2_B) IOWrite1 = 1'b1;
                else                     IOWrite2 = 1'b1;
                rem_d   = rem_q - 6'd1;
                src_d   = src_q + 8'd1;
                dest_d  = dest_q + 8'd1;
                burst_d = burst_q + 7'd1;
                // Preemption is only looked at here, so a started word always finishes.
                if (rem_d == 6'd0) begin
                    state_d = S_DONE;
                end else if (!grant) begin
                    state_d = S_REQ;
                    burst_d = '0;
                end else if ((FAIR_LIMIT != 0) && (burst_d == FAIR_L)) begin
                    state_d = S_YIELD;
                    burst_d = '0;
                end else begin
                    state_d = S_READ;
                end
            end
            S_YIELD: state_d = S_REQ;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data_out  = hold_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_dma_bus_sequencer.sv
// Scoreboard bench: stimulus pushes expected bus writes, a negedge monitor pops and
// compares them; instance b runs with a fairness limit of 2.
module tb_dma_bus_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [7:0]  src, dest;
    logic [5:0]  cnt;

    logic        dv_a, dr_a, breq_a, gnt_a, busy_a, oe_a, mw_a, io1_a, io2_a, done_a;
    logic [7:0]  addr_a;
    logic [31:0] din_a, dout_a;
    logic [5:0]  rem_a;
    logic        dv_b, dr_b, breq_b, gnt_b, busy_b, oe_b, mw_b, io1_b, io2_b, done_b;
    logic [7:0]  addr_b;
    logic [31:0] din_b, dout_b;
    logic [5:0]  rem_b;

    function automatic logic [31:0] pat(input logic [7:0] a);
        return {8'hDA, a, ~a, a ^ 8'h3C};
    endfunction

    assign din_a = pat(addr_a);
    assign din_b = pat(addr_b);

    dma_bus_sequencer dut_a (
        .clock(clock), .reset_n(reset_n), .desc_valid(dv_a), .desc_ready(dr_a),
        .desc_src(src), .desc_dest(dest), .desc_count(cnt), .bus_req(breq_a),
        .grant(gnt_a), .busybus(busy_a), .address(addr_a), .data_in(din_a),
        .data_out(dout_a), .data_oe(oe_a), .memwrite(mw_a), .IOWrite1(io1_a),
        .IOWrite2(io2_a), .done(done_a), .remaining(rem_a)
    );

    dma_bus_sequencer #(.FAIR_LIMIT(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .desc_valid(dv_b), .desc_ready(dr_b),
        .desc_src(src), .desc_dest(dest), .desc_count(cnt), .bus_req(breq_b),
        .grant(gnt_b), .busybus(busy_b), .address(addr_b), .data_in(din_b),
        .data_out(dout_b), .data_oe(oe_b), .memwrite(mw_b), .IOWrite1(io1_b),
        .IOWrite2(io2_b), .done(done_b), .remaining(rem_b)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [2:0]  strb;   // {IOWrite2, IOWrite1, memwrite}
    } wr_t;

    wr_t expq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] dec(input logic [7:0] a);
        if (a < 8'd192) return 3'b001;
        if (a < 8'd224) return 3'b010;
        return 3'b100;
    endfunction

    task automatic push_words(input logic [7:0] s, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] sa, da;
            wr_t e;
            sa = s + 8'(i);
            da = d + 8'(i);
            e.addr = da;
            e.data = pat(sa);
            e.strb = dec(da);
            expq.push_back(e);
        end
    endtask

    task automatic mon(input string who, input logic [7:0] a, input logic [31:0] d,
                       input logic [2:0] s);
        wr_t e;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_write: got addr %0d expected no write", who, a);
        end else begin
            e = expq.pop_front();
            chk({who, "_wr_addr"}, {24'h0, a}, {24'h0, e.addr});
            chk({who, "_wr_data"}, d, e.data);
            chk({who, "_wr_strobe"}, {29'h0, s}, {29'h0, e.strb});
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (reset_n === 1'b1) begin
            if (oe_a) mon("a", addr_a, dout_a, {io2_a, io1_a, mw_a});
            else      chk("a_strobe_idle", {29'h0, io2_a, io1_a, mw_a}, 32'h0);
            if (oe_b) mon("b", addr_b, dout_b, {io2_b, io1_b, mw_b});
            else      chk("b_strobe_idle", {29'h0, io2_b, io1_b, mw_b}, 32'h0);
        end
    end

    task automatic start(input int inst, input logic [7:0] s, input logic [7:0] d,
                         input logic [5:0] n, output int c);
        @(negedge clock);
        chk("desc_ready", {31'h0, (inst == 0) ? dr_a : dr_b}, 32'h1);
        src = s; dest = d; cnt = n;
        if (inst == 0) dv_a = 1'b1; else dv_b = 1'b1;
        c = cyc;
        @(posedge clock);
        #1;
        dv_a = 1'b0;
        dv_b = 1'b0;
    endtask

    task automatic wait_busy_a(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (busy_a) begin at = cyc; break; end
        end
        if (at < 0) chk("a_busy_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_done_a(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (done_a) begin at = cyc; break; end
        end
        if (at < 0) chk("a_done_timeout", 32'h0, 32'h1);
    endtask

    task automatic run_a(input logic [7:0] s, input logic [7:0] d, input logic [5:0] n);
        int c, td;
        push_words(s, d, int'(n));
        start(0, s, d, n, c);
        wait_done_a(4 * int'(n) + 10, td);
        chk("a_queue_drained", expq.size(), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t0, t1, td, blo;
        int yl[$];
        reset_n = 1'b0;
        dv_a = 1'b0; dv_b = 1'b0; gnt_a = 1'b0; gnt_b = 1'b0;
        src = '0; dest = '0; cnt = '0;

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_desc_ready", {31'h0, dr_a}, 32'h1);
        chk("rst_bus_req", {31'h0, breq_a}, 32'h0);
        chk("rst_busybus", {31'h0, busy_a}, 32'h0);
        chk("rst_address", {24'h0, addr_a}, 32'h0);
        chk("rst_data_out", dout_a, 32'h0);
        chk("rst_remaining", {26'h0, rem_a}, 32'h0);
        chk("rst_done", {31'h0, done_a}, 32'h0);
        reset_n = 1'b1;

        // basic memory copy with grant tied high
        gnt_a = 1'b1;
        push_words(8'd10, 8'd50, 3);
        start(0, 8'd10, 8'd50, 6'd3, c);
        wait_busy_a(10, t0);
        chk("basic_first_read_cycle", t0, c + 2);
        chk("basic_first_read_addr", {24'h0, addr_a}, 32'd10);
        wait_done_a(20, td);
        chk("basic_done_latency", td - t0, 32'd6);
        chk("basic_remaining_zero", {26'h0, rem_a}, 32'h0);
        chk("basic_queue_drained", expq.size(), 32'h0);

        // IO decode, address wrap and decode boundaries
        run_a(8'd5, 8'd254, 6'd4);
        run_a(8'd100, 8'd192, 6'd1);
        run_a(8'd101, 8'd191, 6'd1);
        run_a(8'd255, 8'd223, 6'd2);

        // zero-length descriptor never touches the bus
        gnt_a = 1'b0;
        start(0, 8'd7, 8'd9, 6'd0, c);
        @(negedge clock);
        chk("zero_done_pulse", {31'h0, done_a}, 32'h1);
        chk("zero_no_bus_req", {31'h0, breq_a}, 32'h0);
        @(negedge clock);
        chk("zero_done_single", {31'h0, done_a}, 32'h0);
        chk("zero_back_idle", {31'h0, dr_a}, 32'h1);
        chk("zero_no_bus_req2", {31'h0, breq_a}, 32'h0);

        // preemption during the second word
        gnt_a = 1'b1;
        push_words(8'd20, 8'd100, 5);
        start(0, 8'd20, 8'd100, 6'd5, c);
        wait_busy_a(10, t0);
        @(negedge clock);
        @(negedge clock);
        chk("preempt_read2_addr", {24'h0, addr_a}, 32'd21);
        gnt_a = 1'b0;
        @(negedge clock);
        chk("preempt_write2_oe", {31'h0, oe_a}, 32'h1);
        chk("preempt_write2_addr", {24'h0, addr_a}, 32'd101);
        @(negedge clock);
        chk("preempt_req", {31'h0, breq_a}, 32'h1);
        chk("preempt_not_busy", {31'h0, busy_a}, 32'h0);
        chk("preempt_remaining", {26'h0, rem_a}, 32'd3);
        repeat (3) @(negedge clock);
        chk("preempt_still_req", {31'h0, breq_a}, 32'h1);
        chk("preempt_still_idle_bus", {31'h0, busy_a}, 32'h0);
        gnt_a = 1'b1;
        wait_busy_a(5, t1);
        chk("preempt_resume_addr", {24'h0, addr_a}, 32'd22);
        wait_done_a(20, td);
        chk("preempt_queue_drained", expq.size(), 32'h0);

        // reset in the middle of a transfer
        push_words(8'd40, 8'd60, 1);
        start(0, 8'd40, 8'd60, 6'd4, c);
        wait_busy_a(10, t0);
        @(negedge clock);
        chk("midrst_in_write", {31'h0, oe_a}, 32'h1);
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_strobes", {29'h0, io2_a, io1_a, mw_a}, 32'h0);
        chk("midrst_busybus", {31'h0, busy_a}, 32'h0);
        chk("midrst_desc_ready", {31'h0, dr_a}, 32'h1);
        chk("midrst_no_done", {31'h0, done_a}, 32'h0);
        chk("midrst_remaining", {26'h0, rem_a}, 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("midrst_quiet_done", {31'h0, done_a}, 32'h0);
            chk("midrst_quiet_req", {31'h0, breq_a}, 32'h0);
        end
        chk("midrst_queue_drained", expq.size(), 32'h0);

        // fairness limit of 2 on instance b
        gnt_b = 1'b1;
        push_words(8'd30, 8'd70, 5);
        start(1, 8'd30, 8'd70, 6'd5, c);
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (busy_b) begin t0 = cyc; break; end
        end
        chk("fair_started", {31'h0, t0 >= 0}, 32'h1);
        td = -1;
        blo = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done_b) begin td = cyc; break; end
            if (!breq_b) yl.push_back(cyc);
            if (!busy_b) blo++;
        end
        chk("fair_done_latency", td - t0, 32'd14);
        chk("fair_yield_count", yl.size(), 32'd2);
        if (yl.size() == 2) begin
            chk("fair_yield1_cycle", yl[0] - t0, 32'd4);
            chk("fair_yield2_cycle", yl[1] - t0, 32'd10);
        end
        chk("fair_bus_idle_cycles", blo, 32'd4);
        chk("fair_queue_drained", expq.size(), 32'h0);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
